// File: rtl/id_stage_controller_if.sv
// Fetch-side and execute-side handshake bundle for the decode-stage controller.
// The slave modport is the controller; the master modport is its environment.
interface id_stage_controller_if;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        ex_ready;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [3:0]  imm_sel;
  logic        imm_used;
  logic        illegal;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        bubble;

  modport slave (
    input  if_valid, if_inst, if_pc, ex_ready, flush,
    output if_ready, id_valid, id_inst, id_pc, imm_sel, imm_used, illegal,
           rs1, rs2, rd, bubble
  );

  modport master (
    output if_valid, if_inst, if_pc, ex_ready, flush,
    input  if_ready, id_valid, id_inst, id_pc, imm_sel, imm_used, illegal,
           rs1, rs2, rd, bubble
  );
endinterface

// File: rtl/id_stage_controller.sv
// RV32IM decode-stage sequencer: IF/ID holding register, immediate-select decode,
// load-use bubble insertion and flush handling.
module id_stage_controller #(
  parameter logic [31:0] NOP_INST      = 32'h00000013,
  parameter bit          HAZARD_DETECT = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  id_stage_controller_if.slave        bus
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OP_W  = 7;

  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_REG    = 7'b0110011;
  localparam logic [OP_W-1:0] OP_FENCE  = 7'b0001111;
  localparam logic [OP_W-1:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {EMPTY, FULL, STALL} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              ld_vld_q, ld_vld_d;
  logic [REG_W-1:0]  ld_rd_q, ld_rd_d;

  logic              if_ready_c;
  logic              in_xfer_c;
  logic              out_xfer_c;
  logic              hazard_c;
  logic [3:0]        imm_sel_c;
  logic              imm_used_c;
  logic              illegal_c;

  logic [OP_W-1:0]   held_op;
  logic [REG_W-1:0]  held_rd;
  logic [OP_W-1:0]   in_op;
  logic [REG_W-1:0]  in_rs1;
  logic [REG_W-1:0]  in_rs2;

  function automatic logic uses_rs1(input logic [OP_W-1:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [OP_W-1:0] op);
    return (op == OP_REG || op == OP_BRANCH || op == OP_STORE);
  endfunction

  assign held_op = inst_q[6:0];
  assign held_rd = inst_q[11:7];
  assign in_op   = bus.if_inst[6:0];
  assign in_rs1  = bus.if_inst[19:15];
  assign in_rs2  = bus.if_inst[24:20];

  // Handshake qualifiers; if_ready never looks at the fetch side.
  always_comb begin
    if_ready_c = !bus.flush && (state_q == EMPTY || (state_q == FULL && bus.ex_ready));
    in_xfer_c  = bus.if_valid && if_ready_c;
    out_xfer_c = (state_q == FULL) && bus.ex_ready;
  end

  // Track the load now entering EX; the hazard check uses the post-edge value.
  always_comb begin
    ld_vld_d = ld_vld_q;
    ld_rd_d  = ld_rd_q;
    if (bus.flush) begin
      ld_vld_d = 1'b0;
      ld_rd_d  = '0;
    end else if (out_xfer_c) begin
      ld_vld_d = (held_op == OP_LOAD) && (held_rd != '0);
      ld_rd_d  = held_rd;
    end else if (bus.ex_ready) begin
      ld_vld_d = 1'b0;
      ld_rd_d  = '0;
    end
    hazard_c = HAZARD_DETECT && ld_vld_d &&
               ((uses_rs1(in_op) && in_rs1 == ld_rd_d) ||
                (uses_rs2(in_op) && in_rs2 == ld_rd_d));
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    if (bus.flush) begin
      state_d = EMPTY;
      inst_d  = NOP_INST;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer_c) begin
            inst_d  = bus.if_inst;
            pc_d    = bus.if_pc;
            state_d = hazard_c ? STALL : FULL;
          end
        end
        FULL: begin
          if (out_xfer_c) begin
            if (in_xfer_c) begin
              inst_d  = bus.if_inst;
              pc_d    = bus.if_pc;
              state_d = hazard_c ? STALL : FULL;
            end else begin
              state_d = EMPTY;
            end
          end
        end
        STALL: begin
          if (bus.ex_ready) state_d = FULL;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= EMPTY;
      inst_q   <= NOP_INST;
      pc_q     <= '0;
      ld_vld_q <= 1'b0;
      ld_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      ld_vld_q <= ld_vld_d;
      ld_rd_q  <= ld_rd_d;
    end
  end

  // Immediate-select decode of the held instruction.
  always_comb begin
    imm_sel_c  = 4'b0000;
    imm_used_c = 1'b1;
    illegal_c  = 1'b0;
    case (held_op)
      OP_LUI, OP_AUIPC: imm_sel_c = 4'b0000;
      OP_JAL:           imm_sel_c = 4'b0001;
      OP_LOAD, OP_JALR: imm_sel_c = 4'b0010;
      OP_IMM: begin
        case (inst_q[14:12])
          3'b001, 3'b101: imm_sel_c = 4'b0101;
          3'b011:         imm_sel_c = 4'b1010;
          default:        imm_sel_c = 4'b0010;
        endcase
      end
      OP_BRANCH: imm_sel_c = (inst_q[14:13] == 2'b11) ? 4'b1011 : 4'b0011;
      OP_STORE:  imm_sel_c = 4'b0100;
      OP_REG, OP_FENCE, OP_SYSTEM: imm_used_c = 1'b0;
      default: begin
        imm_used_c = 1'b0;
        illegal_c  = 1'b1;
      end
    endcase
  end

  assign bus.if_ready = if_ready_c;
  assign bus.id_valid = (state_q == FULL);
  assign bus.bubble   = (state_q == STALL);
  assign bus.id_inst  = inst_q;
  assign bus.id_pc    = pc_q;
  assign bus.rs1      = inst_q[19:15];
  assign bus.rs2      = inst_q[24:20];
  assign bus.rd       = inst_q[11:7];
  assign bus.imm_sel  = imm_sel_c;
  assign bus.imm_used = imm_used_c;
  assign bus.illegal  = illegal_c;

endmodule

// File: tb/tb_id_stage_controller.sv
// Scoreboard bench for id_stage_controller: directed instructions push expected
// issues/bubbles; a negedge monitor pops and compares on every EX-side transfer.
module tb_id_stage_controller;

  localparam logic [31:0] NOP       = 32'h00000013;
  localparam logic [31:0] ADDI_X1   = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] LUI_X2    = 32'h12345137; // lui x2,0x12345
  localparam logic [31:0] SW_X1     = 32'h00112223; // sw x1,4(x2)
  localparam logic [31:0] BLTU_X1   = 32'h0020E463; // bltu x1,x2,8
  localparam logic [31:0] LW_X5     = 32'h0000A283; // lw x5,0(x1)
  localparam logic [31:0] ADD_X5    = 32'h00128333; // add x6,x5,x1
  localparam logic [31:0] LW_X0     = 32'h0000A003; // lw x0,0(x1)
  localparam logic [31:0] ADD_X0    = 32'h00100333; // add x6,x0,x1
  localparam logic [31:0] SW_X5     = 32'h0050A023; // sw x5,0(x1)
  localparam logic [31:0] ADDI_X7   = 32'h00508393; // addi x7,x1,5 (rs2 field = 5)
  localparam logic [31:0] SLLI_X3   = 32'h00209193; // slli x3,x1,2
  localparam logic [31:0] SLTIU_X4  = 32'h0010B213; // sltiu x4,x1,1
  localparam logic [31:0] JAL_X1    = 32'h010000EF; // jal x1,16
  localparam logic [31:0] ILL_OP    = 32'h0000007F;

  typedef struct packed {
    logic        bub;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [3:0]  sel;
    logic        used;
    logic        ill;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  id_stage_controller_if bus();

  id_stage_controller #(
    .NOP_INST     (32'h00000013),
    .HAZARD_DETECT(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_issue(input logic [31:0] inst, input logic [31:0] pc,
                              input logic [3:0] sel, input logic used, input logic ill,
                              input logic bub_first);
    exp_t e;
    if (bub_first) begin
      e = '0;
      e.bub = 1'b1;
      exp_q.push_back(e);
    end
    e = '{bub: 1'b0, inst: inst, pc: pc, sel: sel, used: used, ill: ill};
    exp_q.push_back(e);
  endtask

  // Present one instruction until accepted; returns at posedge+1 after the transfer.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    bus.if_valid = 1'b1;
    bus.if_inst  = inst;
    bus.if_pc    = pc;
    while (!ok && waits < 20) begin
      @(negedge clk);
      if (bus.if_ready) ok = 1'b1;
      else waits++;
    end
    if (!ok) check("accept_timeout", 32'(waits), 32'd0);
    @(posedge clk);
    #1;
    bus.if_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every EX-side transfer (issue or consumed bubble) must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.ex_ready && (bus.id_valid || bus.bubble)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", bus.id_inst, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_bubble", 32'(bus.bubble), 32'(e.bub));
        if (!e.bub) begin
          check("sb_inst", bus.id_inst, e.inst);
          check("sb_pc", bus.id_pc, e.pc);
          check("sb_imm_sel", 32'(bus.imm_sel), 32'(e.sel));
          check("sb_imm_used", 32'(bus.imm_used), 32'(e.used));
          check("sb_illegal", 32'(bus.illegal), 32'(e.ill));
          check("sb_rs1", 32'(bus.rs1), 32'(e.inst[19:15]));
          check("sb_rd", 32'(bus.rd), 32'(e.inst[11:7]));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_id_valid"}, 32'(bus.id_valid), 32'd0);
    check({tag, "_bubble"}, 32'(bus.bubble), 32'd0);
    check({tag, "_id_inst"}, bus.id_inst, NOP);
    check({tag, "_id_pc"}, bus.id_pc, 32'd0);
    check({tag, "_imm_sel"}, 32'(bus.imm_sel), 32'h2);
    check({tag, "_imm_used"}, 32'(bus.imm_used), 32'd1);
    check({tag, "_illegal"}, 32'(bus.illegal), 32'd0);
  endtask

  initial begin
    int w;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_inst  = '0;
    bus.if_pc    = '0;
    bus.ex_ready = 1'b1;
    bus.flush    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    check("rst_if_ready", 32'(bus.if_ready), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;

    // Back-to-back stream, one issue per cycle
    expect_issue(ADDI_X1, 32'h100, 4'b0010, 1'b1, 1'b0, 1'b0);
    send(ADDI_X1, 32'h100, w);
    check("s0_wait", 32'(w), 0); check("s0_pc", bus.id_pc, 32'h100);
    expect_issue(LUI_X2, 32'h104, 4'b0000, 1'b1, 1'b0, 1'b0);
    send(LUI_X2, 32'h104, w);
    check("s1_wait", 32'(w), 0); check("s1_pc", bus.id_pc, 32'h104);
    expect_issue(SW_X1, 32'h108, 4'b0100, 1'b1, 1'b0, 1'b0);
    send(SW_X1, 32'h108, w);
    check("s2_wait", 32'(w), 0); check("s2_pc", bus.id_pc, 32'h108);
    expect_issue(BLTU_X1, 32'h10C, 4'b1011, 1'b1, 1'b0, 1'b0);
    send(BLTU_X1, 32'h10C, w);
    check("s3_wait", 32'(w), 0); check("s3_valid", 32'(bus.id_valid), 32'd1);
    idle(2);

    // Load-use on rs1: exactly one bubble
    expect_issue(LW_X5, 32'h200, 4'b0010, 1'b1, 1'b0, 1'b0);
    send(LW_X5, 32'h200, w);
    expect_issue(ADD_X5, 32'h204, 4'b0000, 1'b0, 1'b0, 1'b1);
    send(ADD_X5, 32'h204, w);
    check("lu_bubble", 32'(bus.bubble), 32'd1);
    check("lu_id_valid", 32'(bus.id_valid), 32'd0);
    check("lu_if_ready", 32'(bus.if_ready), 32'd0);
    idle(1);
    check("lu_issue_valid", 32'(bus.id_valid), 32'd1);
    check("lu_issue_inst", bus.id_inst, ADD_X5);
    // Load to x0 never stalls
    expect_issue(LW_X0, 32'h210, 4'b0010, 1'b1, 1'b0, 1'b0);
    send(LW_X0, 32'h210, w);
    expect_issue(ADD_X0, 32'h214, 4'b0000, 1'b0, 1'b0, 1'b0);
    send(ADD_X0, 32'h214, w);
    check("x0_bubble", 32'(bus.bubble), 32'd0);
    check("x0_valid", 32'(bus.id_valid), 32'd1);
    // Store data (rs2) hazard, then an OP-IMM whose imm bits alias rs2
    expect_issue(LW_X5, 32'h220, 4'b0010, 1'b1, 1'b0, 1'b0);
    send(LW_X5, 32'h220, w);
    expect_issue(SW_X5, 32'h224, 4'b0100, 1'b1, 1'b0, 1'b1);
    send(SW_X5, 32'h224, w);
    check("rs2_bubble", 32'(bus.bubble), 32'd1);
    expect_issue(LW_X5, 32'h228, 4'b0010, 1'b1, 1'b0, 1'b0);
    send(LW_X5, 32'h228, w);
    expect_issue(ADDI_X7, 32'h22C, 4'b0010, 1'b1, 1'b0, 1'b0);
    send(ADDI_X7, 32'h22C, w);
    check("imm_alias_bubble", 32'(bus.bubble), 32'd0);
    check("imm_alias_valid", 32'(bus.id_valid), 32'd1);
    idle(2);

    // EX back-pressure for 3 cycles while FULL
    expect_issue(ADDI_X1, 32'h300, 4'b0010, 1'b1, 1'b0, 1'b0);
    send(ADDI_X1, 32'h300, w);
    bus.ex_ready = 1'b0;
    bus.if_valid = 1'b1;
    bus.if_inst  = SLLI_X3;
    bus.if_pc    = 32'h304;
    expect_issue(SLLI_X3, 32'h304, 4'b0101, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(bus.id_valid), 32'd1);
      check("bp_inst", bus.id_inst, ADDI_X1);
      check("bp_pc", bus.id_pc, 32'h300);
      check("bp_imm_sel", 32'(bus.imm_sel), 32'h2);
      check("bp_if_ready", 32'(bus.if_ready), 32'd0);
    end
    @(posedge clk);
    #1 bus.ex_ready = 1'b1;
    @(negedge clk);
    check("bp_release_if_ready", 32'(bus.if_ready), 32'd1);
    @(posedge clk);
    #1 bus.if_valid = 1'b0;
    check("bp_release_inst", bus.id_inst, SLLI_X3);
    expect_issue(SLTIU_X4, 32'h308, 4'b1010, 1'b1, 1'b0, 1'b0);
    send(SLTIU_X4, 32'h308, w);
    expect_issue(JAL_X1, 32'h30C, 4'b0001, 1'b1, 1'b0, 1'b0);
    send(JAL_X1, 32'h30C, w);
    expect_issue(ILL_OP, 32'h310, 4'b0000, 1'b0, 1'b1, 1'b0);
    send(ILL_OP, 32'h310, w);
    check("ill_flag", 32'(bus.illegal), 32'd1);
    idle(2);

    // Flush while FULL with fetch offering an instruction
    bus.ex_ready = 1'b0;
    send(ADDI_X1, 32'h400, w);
    bus.flush    = 1'b1;
    bus.if_valid = 1'b1;
    bus.if_inst  = LUI_X2;
    bus.if_pc    = 32'h404;
    @(negedge clk);
    check("fl_if_ready", 32'(bus.if_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    check("fl_valid", 32'(bus.id_valid), 32'd0);
    check("fl_inst", bus.id_inst, NOP);
    check("fl_bubble", 32'(bus.bubble), 32'd0);
    bus.ex_ready = 1'b1;
    idle(2);
    check("fl_no_accept", 32'(bus.id_valid), 32'd0);

    // Flush while STALL cancels the bubble and the stalled instruction
    expect_issue(LW_X5, 32'h500, 4'b0010, 1'b1, 1'b0, 1'b0);
    send(LW_X5, 32'h500, w);
    send(ADD_X5, 32'h504, w);
    bus.ex_ready = 1'b0;
    bus.flush    = 1'b1;
    check("fs_pre_bubble", 32'(bus.bubble), 32'd1);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    check("fs_bubble", 32'(bus.bubble), 32'd0);
    check("fs_valid", 32'(bus.id_valid), 32'd0);
    check("fs_inst", bus.id_inst, NOP);
    bus.ex_ready = 1'b1;
    idle(2);
    check("fs_no_issue", 32'(bus.id_valid), 32'd0);

    // Asynchronous reset in the middle of a stall
    expect_issue(LW_X5, 32'h600, 4'b0010, 1'b1, 1'b0, 1'b0);
    send(LW_X5, 32'h600, w);
    send(ADD_X5, 32'h604, w);
    bus.ex_ready = 1'b0;
    check("ar_pre_bubble", 32'(bus.bubble), 32'd1);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("ar");
    check("ar_if_ready", 32'(bus.if_ready), 32'd1);
    idle(2);
    reset = 1'b1;
    // Load record was cleared by reset: no bubble even with EX stalled
    expect_issue(ADD_X5, 32'h700, 4'b0000, 1'b0, 1'b0, 1'b0);
    send(ADD_X5, 32'h700, w);
    check("ar_post_bubble", 32'(bus.bubble), 32'd0);
    check("ar_post_valid", 32'(bus.id_valid), 32'd1);
    bus.ex_ready = 1'b1;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    idle(1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_controller.md
Name: id_stage_controller

Overview:
- Decode-stage sequencer for the RV32IM pipeline, sitting between the fetch stage and the execute stage.
- Holds one fetched instruction in the IF/ID register and decodes the 4-bit SELECT code that drives the immediate select datapath.
- Detects load-use hazards against the instruction last issued to EX and inserts one bubble when one is found.
- Handles valid/ready handshakes on both sides and honours pipeline flushes.

Parameters:
- NOP_INST, 32'h00000013: instruction value loaded into the register on reset and on flush.
- HAZARD_DETECT, 1: 1 enables load-use bubble insertion; 0 never stalls.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-low reset.
- IF_VALID  input  1  fetch presents an instruction.
- IF_INST  input  32  fetched instruction.
- IF_PC  input  32  PC of the fetched instruction.
- IF_READY  output  1  controller accepts the fetched instruction this cycle.
- EX_READY  input  1  execute stage advances this cycle.
- FLUSH  input  1  branch/jump redirect from EX.
- ID_VALID  output  1  issued instruction is valid.
- ID_INST  output  32  held instruction.
- ID_PC  output  32  held PC.
- IMM_SEL  output  4  SELECT code for immediate select.
- IMM_USED  output  1  instruction consumes an immediate.
- ILLEGAL  output  1  unrecognised opcode.
- RS1, RS2, RD  output  5 each  register fields of the held instruction.
- BUBBLE  output  1  a hazard bubble is being presented.

Behaviour:
- States: EMPTY, FULL, STALL.
- Reset (RESET=0, async): state=EMPTY, ID_INST=NOP_INST, ID_PC=0, load record cleared.
  - Reset-value outputs: ID_VALID=0, BUBBLE=0, IMM_SEL=4'b0010, IMM_USED=1, ILLEGAL=0.
- Transfer rules: input transfer = IF_VALID && IF_READY; output transfer = ID_VALID && EX_READY.
- IF_READY = !FLUSH && (state==EMPTY || (state==FULL && EX_READY)). Always 0 in STALL.
- Output levels by state:
  - ID_VALID=1 only in FULL.
  - BUBBLE=1 only in STALL.
  - Decoded outputs are combinational from the held register and stay stable while ID_VALID && !EX_READY.
- Load record: {valid, rd} of the instruction now in EX.
  - On output transfer: set to (opcode 0000011 && rd!=0) ? rd : cleared.
  - On any cycle with EX_READY=1 and no output transfer: cleared.
- Hazard:
  - Condition: HAZARD_DETECT && the next value of the load record is valid && the incoming instruction uses rs1 or rs2 equal to that rd.
  - rs1 is used by every opcode except LUI, AUIPC and JAL.
  - rs2 is used only by R-type (0110011), branch and store.
- Transitions (FLUSH has top priority):
  - FLUSH=1: go to EMPTY, load NOP_INST, clear the load record, discard IF input.
  - EMPTY: on input transfer, latch the instruction; go to STALL if a hazard exists, else FULL.
  - FULL, output transfer with an input transfer: latch the new instruction; go to STALL if a hazard exists (checked against the just-issued instruction), else stay in FULL.
  - FULL, output transfer without an input transfer: go to EMPTY.
  - FULL, no output transfer: hold.
  - STALL: when EX_READY=1 the bubble is consumed; go to FULL. Otherwise hold.
- Latency: one cycle from input transfer to ID_VALID when there is no hazard; two cycles with a hazard and EX_READY held at 1.
- IMM_SEL decode, by opcode:
  - LUI 0110111, AUIPC 0010111 → 0000.
  - JAL 1101111 → 0001.
  - LOAD 0000011, JALR 1100111 → 0010.
  - OP-IMM 0010011: funct3 001/101 → 0101; funct3 011 (SLTIU) → 1010; otherwise → 0010.
  - BRANCH 1100011: funct3 110/111 → 1011; otherwise → 0011.
  - STORE 0100011 → 0100.
  - R-type, FENCE 0001111, SYSTEM 1110011 → 0000 with IMM_USED=0.
  - Any other opcode → 0000, IMM_USED=0, ILLEGAL=1.
- No combinational path from IF_* to ID_*. IF_READY depends combinationally on EX_READY and FLUSH only.

Test Plan:
- Reset, then a stream of ADDI/LUI/SW/BLTU with EX_READY=1 → one issue per cycle. IMM_SEL sequence is 0010, 0000, 0100, 1011. ID_PC matches IF_PC delayed one cycle.
- LW x5 followed by ADD x6,x5,x1 → LW issues; next cycle BUBBLE=1 and ID_VALID=0. ADD issues one cycle later, so the total penalty is exactly one cycle. Repeat with LW x0 → no bubble.
- EX_READY=0 for 3 cycles while FULL → ID_* stable and IF_READY=0 for all 3 cycles. Release → issue and accept in the same cycle.
- FLUSH asserted in FULL with IF_VALID=1 → next cycle state EMPTY, ID_VALID=0, ID_INST=32'h00000013, and the input is not accepted. Also apply FLUSH in STALL → bubble cancelled, no issue.
- RESET pulled low mid-STALL, asynchronously between clock edges → outputs take reset values immediately.
- Opcode 1111111 → ILLEGAL=1, IMM_USED=0. SLLI → 0101. SLTIU → 1010. JAL → 0001.
